// File: rtl/mem_arbiter_if.sv
// Requester, halt and memory-side signals of the shared instruction/data memory arbiter.
// slave is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              ifReq;
  logic [ADDR_W-1:0] ifAddr;
  logic [DATA_W-1:0] ifRdata;
  logic              ifAck;
  logic              dReq;
  logic              dWe;
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] dWdata;
  logic [DATA_W-1:0] dRdata;
  logic              dAck;
  logic              haltIn;
  logic              halted;
  logic              memEn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] memRdata;
  logic              memReady;

  modport slave (
    input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, haltIn, memRdata, memReady,
    output ifRdata, ifAck, dRdata, dAck, halted, memEn, memWe, memAddr, memWdata
  );

  modport master (
    output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, haltIn, memRdata, memReady,
    input  ifRdata, ifAck, dRdata, dAck, halted, memEn, memWe, memAddr, memWdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between fetch and data access. Data has priority,
// bounded by a starvation counter; a latched halt stops further fetches.
module mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, FETCH, DATA, RESP, HALTED} state_t;

  state_t            state, nextState;
  logic [CW-1:0]     starveCnt;
  logic              haltLatched;
  logic [DATA_W-1:0] rdata;
  logic              memEn, memWe, ifAck, dAck, halted;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              dataWin, fetchWin;

  // Data wins unless a pending fetch has already been passed over STARVE_LIMIT times.
  always_comb begin
    dataWin  = bus.dReq && !(bus.ifReq && !haltLatched && starveCnt == LIM);
    fetchWin = !dataWin && bus.ifReq && !haltLatched;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (dataWin)                        nextState = DATA;
        else if (fetchWin)                  nextState = FETCH;
        else if (haltLatched && !bus.dReq)  nextState = HALTED;
      end
      FETCH, DATA: if (bus.memReady) nextState = RESP;
      RESP:        nextState = IDLE;
      HALTED:      nextState = HALTED;
      default:     nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memEn       <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWdata    <= '0;
      ifAck       <= 1'b0;
      dAck        <= 1'b0;
      halted      <= 1'b0;
      rdata       <= '0;
      starveCnt   <= '0;
      haltLatched <= 1'b0;
    end else begin
      haltLatched <= haltLatched | bus.haltIn;
      ifAck       <= 1'b0;
      dAck        <= 1'b0;
      halted      <= (nextState == HALTED);
      case (state)
        IDLE: begin
          if (dataWin) begin
            memEn    <= 1'b1;
            memWe    <= bus.dWe;
            memAddr  <= bus.dAddr;
            memWdata <= bus.dWdata;
            if (!bus.ifReq)        starveCnt <= '0;
            else if (starveCnt != LIM) starveCnt <= starveCnt + CW'(1);
          end else if (fetchWin) begin
            memEn     <= 1'b1;
            memWe     <= 1'b0;
            memAddr   <= bus.ifAddr;
            memWdata  <= '0;
            starveCnt <= '0;
          end
        end
        FETCH, DATA: begin
          if (bus.memReady) begin
            memEn <= 1'b0;
            if (!memWe) rdata <= bus.memRdata;
            ifAck <= (state == FETCH);
            dAck  <= (state == DATA);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.memEn    = memEn;
  assign bus.memWe    = memWe;
  assign bus.memAddr  = memAddr;
  assign bus.memWdata = memWdata;
  assign bus.ifAck    = ifAck;
  assign bus.dAck     = dAck;
  assign bus.ifRdata  = rdata;
  assign bus.dRdata   = rdata;
  assign bus.halted   = halted;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized mixed traffic against a
// transaction-level memory model and grant-order rules.
module tb_mem_arbiter;
  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] mem    [256];
  logic [15:0] refMem [256];
  int   lat = 0;
  bit   randLat = 1'b0;
  bit   monOn = 1'b0;
  int   run = 0;
  logic smpIf, smpD;
  logic enPrev = 1'b0;
  logic [15:0] grantLog [$];

  // fetch-side and data-side addresses land in separate halves of the model memory
  function automatic int idx(input logic [15:0] a);
    return int'({a[15], a[6:0]});
  endfunction

  // memory responder with programmable or random latency
  initial begin
    int cnt;
    int cur;
    cnt = 0;
    cur = 0;
    bus.memReady = 1'b0;
    bus.memRdata = '0;
    forever begin
      @(negedge clk);
      if (bus.memEn && !bus.memReady) begin
        if (cnt == 0) cur = randLat ? int'($urandom_range(0, 3)) : lat;
        if (cnt >= cur) begin
          bus.memReady = 1'b1;
          bus.memRdata = mem[idx(bus.memAddr)];
          if (bus.memWe) mem[idx(bus.memAddr)] = bus.memWdata;
          cnt = 0;
        end else begin
          cnt++;
          bus.memRdata = 16'($urandom);
        end
      end else begin
        bus.memReady = 1'b0;
        cnt = 0;
        bus.memRdata = 16'($urandom);
      end
    end
  end

  // grant log and, during random traffic, the priority/starvation rules
  initial begin
    forever begin
      @(posedge clk);
      smpIf = bus.ifReq;
      smpD  = bus.dReq;
      @(negedge clk);
      if (bus.memEn && !enPrev) begin
        grantLog.push_back(bus.memAddr);
        if (monOn) begin
          tests++;
          if (bus.memAddr[15]) begin
            run = smpIf ? run + 1 : 0;
            if (run > LIM) begin
              fails++;
              $display("FAIL starve: %0d data grants over a waiting fetch, allowed %0d", run, LIM);
            end
          end else begin
            if (smpD && run != LIM) begin
              fails++;
              $display("FAIL prio: fetch won over data after %0d data grants, required %0d", run, LIM);
            end
            run = 0;
          end
        end
      end
      enPrev = bus.memEn;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // issue one fetch starting just after a rising edge; n = negedges until ack, -1 on timeout
  task automatic doFetch(input logic [15:0] a, output logic [15:0] d, output int n);
    bus.ifAddr = a;
    bus.ifReq  = 1'b1;
    n = -1;
    d = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.ifAck) begin n = i; d = bus.ifRdata; break; end
    end
    @(posedge clk); #1;
    bus.ifReq = 1'b0;
  endtask

  task automatic doData(input logic we, input logic [15:0] a, input logic [15:0] wd,
                        output logic [15:0] rd, output int n);
    bus.dWe    = we;
    bus.dAddr  = a;
    bus.dWdata = wd;
    bus.dReq   = 1'b1;
    n  = -1;
    rd = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (bus.dAck) begin n = i; rd = bus.dRdata; break; end
    end
    @(posedge clk); #1;
    bus.dReq = 1'b0;
  endtask

  task automatic waitEn(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.memEn) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({bus.ifAck, bus.dAck, bus.memEn, bus.memWe, bus.halted} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctl: ifAck,dAck,memEn,memWe,halted=%b required 00000",
               {bus.ifAck, bus.dAck, bus.memEn, bus.memWe, bus.halted});
    end
    tests++;
    if (bus.memAddr !== 16'h0 || bus.memWdata !== 16'h0) begin
      fails++;
      $display("FAIL reset_mem: memAddr=%h memWdata=%h required 0000 0000", bus.memAddr, bus.memWdata);
    end
    tests++;
    if (bus.ifRdata !== 16'h0 || bus.dRdata !== 16'h0) begin
      fails++;
      $display("FAIL reset_rdata: ifRdata=%h dRdata=%h required 0000", bus.ifRdata, bus.dRdata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.memEn !== 1'b0 || bus.halted !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: memEn=%b halted=%b required 0 0", bus.memEn, bus.halted);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    logic [15:0] d;
    int n;
    bit ok;
    mem[idx(16'h0010)] = 16'hBEEF;
    refMem[idx(16'h0010)] = 16'hBEEF;
    lat = 0;
    fork
      doFetch(16'h0010, d, n);
      begin
        waitEn(ok);
        tests++;
        if (!ok || bus.memAddr !== 16'h0010 || bus.memWe !== 1'b0 || bus.memWdata !== 16'h0) begin
          fails++;
          $display("FAIL fetch_grant: en=%0d memAddr=%h memWe=%b memWdata=%h required 0010 0 0000",
                   ok, bus.memAddr, bus.memWe, bus.memWdata);
        end
      end
    join
    tests++;
    if (n != 3 || d !== 16'hBEEF) begin
      fails++;
      $display("FAIL fetch_ack: latency=%0d ifRdata=%h required 3 beef", n, d);
    end
    @(negedge clk);
    tests++;
    if (bus.ifAck !== 1'b0) begin
      fails++;
      $display("FAIL fetch_pulse: ifAck=%b one cycle after ack required 0", bus.ifAck);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    logic [15:0] fd, dd;
    int fn, dn;
    bit ok;
    grantLog.delete();
    fork
      doFetch(16'h0020, fd, fn);
      doData(1'b1, 16'h0200, 16'h1234, dd, dn);
      begin
        waitEn(ok);
        tests++;
        if (!ok || bus.memAddr !== 16'h0200 || bus.memWe !== 1'b1 || bus.memWdata !== 16'h1234) begin
          fails++;
          $display("FAIL prio_grant: memAddr=%h memWe=%b memWdata=%h required 0200 1 1234",
                   bus.memAddr, bus.memWe, bus.memWdata);
        end
      end
    join
    refMem[idx(16'h0200)] = 16'h1234;
    tests++;
    if (dn != 3 || fn < 0 || fd !== refMem[idx(16'h0020)]) begin
      fails++;
      $display("FAIL prio_acks: dLat=%0d fLat=%0d ifRdata=%h required 3 >0 %h",
               dn, fn, fd, refMem[idx(16'h0020)]);
    end
    tests++;
    if (grantLog.size() != 2 || grantLog[0] !== 16'h0200 || grantLog[1] !== 16'h0020) begin
      fails++;
      $display("FAIL prio_order: %0d grants, first=%h required 2 grants 0200 then 0020",
               grantLog.size(), grantLog.size() > 0 ? grantLog[0] : 16'hxxxx);
    end
    doData(1'b0, 16'h0200, 16'h0, dd, dn);
    tests++;
    if (dn < 0 || dd !== 16'h1234) begin
      fails++;
      $display("FAIL write_readback: dRdata=%h required 1234", dd);
    end
  endtask

  task automatic test_starve();
    logic [15:0] fd;
    logic [15:0] exp [6];
    int fn;
    grantLog.delete();
    exp = '{16'h8000, 16'h8002, 16'h8004, 16'h8006, 16'h0100, 16'h8008};
    fork
      doFetch(16'h0100, fd, fn);
      for (int i = 0; i < 5; i++) begin
        logic [15:0] a, rd;
        int n;
        a = 16'h8000 + 16'(i * 2);
        doData(1'b0, a, 16'h0, rd, n);
        tests++;
        if (n < 0 || rd !== refMem[idx(a)]) begin
          fails++;
          $display("FAIL starve_read%0d: dRdata=%h required %h", i, rd, refMem[idx(a)]);
        end
      end
    join
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (i >= grantLog.size() || grantLog[i] !== exp[i]) begin
        fails++;
        $display("FAIL starve_order%0d: granted %h required %h", i,
                 i < grantLog.size() ? grantLog[i] : 16'hxxxx, exp[i]);
      end
    end
    tests++;
    if (fn < 0 || fd !== refMem[idx(16'h0100)]) begin
      fails++;
      $display("FAIL starve_fetch: ifRdata=%h required %h", fd, refMem[idx(16'h0100)]);
    end
  endtask

  task automatic test_wait();
    logic [15:0] rd;
    int n;
    bit ok, stable;
    lat = 7;
    fork
      doData(1'b0, 16'h0044, 16'h0, rd, n);
      begin
        waitEn(ok);
        stable = ok;
        for (int i = 0; i < 7; i++) begin
          if (i > 0) @(negedge clk);
          if (bus.memEn !== 1'b1 || bus.memAddr !== 16'h0044 || bus.dAck !== 1'b0) stable = 1'b0;
        end
        tests++;
        if (!stable) begin
          fails++;
          $display("FAIL wait_hold: memEn=%b memAddr=%h dAck=%b required 1 0044 0 for 7 cycles",
                   bus.memEn, bus.memAddr, bus.dAck);
        end
      end
    join
    tests++;
    if (n != 10 || rd !== refMem[idx(16'h0044)]) begin
      fails++;
      $display("FAIL wait_ack: latency=%0d dRdata=%h required 10 %h", n, rd, refMem[idx(16'h0044)]);
    end
    lat = 0;
  endtask

  task automatic test_random();
    randLat = 1'b1;
    run = 0;
    monOn = 1'b1;
    fork
      for (int i = 0; i < 30; i++) begin
        logic [15:0] a, d;
        int n, g;
        a = {1'b0, 15'($urandom)};
        doFetch(a, d, n);
        tests++;
        if (n < 0 || d !== refMem[idx(a)]) begin
          fails++;
          $display("FAIL rand_fetch%0d: addr=%h ifRdata=%h required %h", i, a, d, refMem[idx(a)]);
        end
        g = int'($urandom_range(0, 3));
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
      end
      for (int i = 0; i < 40; i++) begin
        logic [15:0] a, wd, rd;
        logic we;
        int n, g;
        we = 1'($urandom);
        a  = {1'b1, 15'($urandom)};
        wd = 16'($urandom);
        doData(we, a, wd, rd, n);
        tests++;
        if (n < 0 || (!we && rd !== refMem[idx(a)])) begin
          fails++;
          $display("FAIL rand_data%0d: we=%b addr=%h dRdata=%h required %h", i, we, a, rd, refMem[idx(a)]);
        end
        if (we) refMem[idx(a)] = wd;
        g = int'($urandom_range(0, 2));
        if (g > 0) begin repeat (g) @(posedge clk); #1; end
      end
    join
    monOn = 1'b0;
    randLat = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [15:0] d;
    int n;
    bit ok;
    lat = 20;
    bus.dWe = 1'b1;
    bus.dAddr = 16'h8050;
    bus.dWdata = 16'hAAAA;
    bus.dReq = 1'b1;
    waitEn(ok);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (!ok || bus.memEn !== 1'b0 || bus.dAck !== 1'b0 || bus.memWe !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: started=%0d memEn=%b dAck=%b memWe=%b required 1 0 0 0",
               ok, bus.memEn, bus.dAck, bus.memWe);
    end
    bus.dReq = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lat = 0;
    @(negedge clk);
    tests++;
    if (bus.halted !== 1'b0 || bus.memEn !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: halted=%b memEn=%b required 0 0", bus.halted, bus.memEn);
    end
    @(posedge clk); #1;
    doFetch(16'h0030, d, n);
    tests++;
    if (n != 3 || d !== refMem[idx(16'h0030)]) begin
      fails++;
      $display("FAIL reset_refetch: latency=%0d ifRdata=%h required 3 %h", n, d, refMem[idx(16'h0030)]);
    end
    doData(1'b0, 16'h8050, 16'h0, d, n);
    tests++;
    if (n < 0 || d !== refMem[idx(16'h8050)]) begin
      fails++;
      $display("FAIL reset_abandoned_write: dRdata=%h required %h", d, refMem[idx(16'h8050)]);
    end
  endtask

  task automatic test_halt();
    logic [15:0] fd, dd;
    int fn, dn;
    bit seen, bad;
    lat = 2;
    fork
      doFetch(16'h0040, fd, fn);
      begin
        bit ok;
        waitEn(ok);
        @(posedge clk); #1 bus.haltIn = 1'b1;
        @(posedge clk); #1 bus.haltIn = 1'b0;
      end
      begin
        bit ok;
        waitEn(ok);
        @(posedge clk); #1;
        doData(1'b0, 16'h8060, 16'h0, dd, dn);
      end
    join
    tests++;
    if (fn < 0 || fd !== refMem[idx(16'h0040)]) begin
      fails++;
      $display("FAIL halt_fetch: latency=%0d ifRdata=%h required >0 %h", fn, fd, refMem[idx(16'h0040)]);
    end
    tests++;
    if (dn < 0 || dd !== refMem[idx(16'h8060)]) begin
      fails++;
      $display("FAIL halt_data: latency=%0d dRdata=%h required >0 %h", dn, dd, refMem[idx(16'h8060)]);
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.halted) begin seen = 1'b1; break; end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL halt_enter: halted=%b required 1", bus.halted);
    end
    bus.ifAddr = 16'h0050;
    bus.ifReq = 1'b1;
    bus.dReq = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.memEn || bus.ifAck || bus.dAck || !bus.halted) bad = 1'b1;
    end
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL halt_ignore: memEn=%b ifAck=%b dAck=%b halted=%b required 0 0 0 1",
               bus.memEn, bus.ifAck, bus.dAck, bus.halted);
    end
    bus.ifReq = 1'b0;
    bus.dReq = 1'b0;
  endtask

  initial begin
    bus.ifReq  = 1'b0;
    bus.ifAddr = '0;
    bus.dReq   = 1'b0;
    bus.dWe    = 1'b0;
    bus.dAddr  = '0;
    bus.dWdata = '0;
    bus.haltIn = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'($urandom);
      refMem[i] = mem[i];
    end
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_wait();
    test_random();
    test_reset_mid();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
